// File: rtl/vshift_sequencer_pkg.sv
// rtl/vshift_sequencer_pkg.sv - shared encodings and element shift helper for the vector shift sequencer
package vshift_sequencer_pkg;

    localparam int CHUNK_W     = 128;
    localparam int CHUNK_BYTES = 16;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [2:0] VSEW_8  = 3'd0;
    localparam logic [2:0] VSEW_16 = 3'd1;
    localparam logic [2:0] VSEW_32 = 3'd2;
    localparam logic [2:0] VSEW_64 = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EXE,
        ST_WB,
        ST_DONE
    } state_e;

    // Element arrives zero-extended to 64 bits; caller keeps the low 8<<sew bits.
    function automatic logic [63:0] shift_elem(input logic [1:0]  op,
                                               input logic [63:0] a,
                                               input logic [5:0]  amt,
                                               input logic [1:0]  sew);
        logic [6:0]  ew;
        logic [5:0]  sh;
        logic [63:0] ext;
        ew  = 7'd8 << sew;
        sh  = amt & 6'(ew - 7'd1);
        ext = a;
        if (a[6'(ew - 7'd1)]) begin
            ext = a | ~({64{1'b1}} >> (7'd64 - ew));
        end
        case (op)
            OP_SLL:  shift_elem = a << sh;
            OP_SRL:  shift_elem = a >> sh;
            OP_SRA:  shift_elem = 64'($signed(ext) >>> sh);
            default: shift_elem = '0;
        endcase
    endfunction

endpackage

// File: rtl/vshift_lane.sv
// rtl/vshift_lane.sv - combinational 128-bit per-element sll/srl/sra lane
module vshift_lane
    import vshift_sequencer_pkg::*;
(
    input  logic [1:0]         op_i,
    input  logic [1:0]         vsew_i,
    input  logic [CHUNK_W-1:0] a_i,
    input  logic [CHUNK_W-1:0] b_i,
    input  logic               scalar_en_i,
    input  logic [63:0]        scalar_i,
    output logic [CHUNK_W-1:0] res_o
);

    logic [3:0][CHUNK_W-1:0] res_sew;
    logic                    unused_ok;

    // Only the low log2(SEW) amount bits matter; the rest is folded away here.
    assign unused_ok = ^{scalar_i[63:6], b_i};

    for (genvar s = 0; s < 4; s++) begin : g_sew
        localparam int EW = 8 << s;
        for (genvar e = 0; e < CHUNK_W / EW; e++) begin : g_el
            logic [5:0] amt;
            assign amt = scalar_en_i ? scalar_i[5:0] : b_i[e*EW +: 6];
            assign res_sew[s][e*EW +: EW] =
                EW'(shift_elem(op_i, 64'(a_i[e*EW +: EW]), amt, 2'(s)));
        end
    end

    assign res_o = res_sew[vsew_i];

endmodule

// File: rtl/vshift_sequencer.sv
// rtl/vshift_sequencer.sv - chunked VRF read / shift / write-back controller for vsll/vsrl/vsra
module vshift_sequencer
    import vshift_sequencer_pkg::*;
#(
    parameter int MAX_CHUNKS = 8,
    parameter int VL_W       = $clog2(MAX_CHUNKS*16)+1,
    parameter int IDX_W      = $clog2(MAX_CHUNKS)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             op_i,
    input  logic [2:0]             vsew_i,
    input  logic [VL_W-1:0]        vl_i,
    input  logic                   scalar_en_i,
    input  logic [63:0]            scalar_i,
    output logic                   rd_req_o,
    output logic [IDX_W-1:0]       rd_idx_o,
    input  logic [CHUNK_W-1:0]     rd_a_i,
    input  logic [CHUNK_W-1:0]     rd_b_i,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [IDX_W-1:0]       wb_idx_o,
    output logic [CHUNK_W-1:0]     wb_data_o,
    output logic [CHUNK_BYTES-1:0] wb_be_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int TB_W = VL_W + 3;
    localparam int NC_W = IDX_W + 1;

    state_e                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [1:0]             vsew_q, vsew_d;
    logic                   scalar_en_q, scalar_en_d;
    logic [63:0]            scalar_q, scalar_d;
    logic [TB_W-1:0]        total_q, total_d;
    logic [NC_W-1:0]        nchunks_q, nchunks_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   err_q, err_d;
    logic [CHUNK_W-1:0]     wb_data_q, wb_data_d;
    logic [IDX_W-1:0]       wb_idx_q, wb_idx_d;
    logic [CHUNK_BYTES-1:0] wb_be_q, wb_be_d;

    logic                   bad_req;
    logic [VL_W-1:0]        vl_max, vl_clamp;
    logic [TB_W-1:0]        total_acc, rem;
    logic [CHUNK_W-1:0]     lane_res;
    logic                   last_chunk;

    assign bad_req    = (op_i == OP_RSVD) || (vsew_i > VSEW_64);
    assign vl_max     = VL_W'((CHUNK_BYTES * MAX_CHUNKS) >> vsew_i[1:0]);
    assign vl_clamp   = (vl_i > vl_max) ? vl_max : vl_i;
    assign total_acc  = TB_W'(vl_clamp) << vsew_i[1:0];
    assign rem        = total_q - (TB_W'(idx_q) << 4);
    assign last_chunk = (NC_W'(idx_q) + 1'b1) == nchunks_q;

    vshift_lane u_lane (
        .op_i        (op_q),
        .vsew_i      (vsew_q),
        .a_i         (rd_a_i),
        .b_i         (rd_b_i),
        .scalar_en_i (scalar_en_q),
        .scalar_i    (scalar_q),
        .res_o       (lane_res)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        vsew_d      = vsew_q;
        scalar_en_d = scalar_en_q;
        scalar_d    = scalar_q;
        total_d     = total_q;
        nchunks_d   = nchunks_q;
        idx_d       = idx_q;
        err_d       = err_q;
        wb_data_d   = wb_data_q;
        wb_idx_d    = wb_idx_q;
        wb_be_d     = wb_be_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d        = op_i;
                    vsew_d      = vsew_i[1:0];
                    scalar_en_d = scalar_en_i;
                    scalar_d    = scalar_i;
                    total_d     = total_acc;
                    nchunks_d   = NC_W'((total_acc + TB_W'(CHUNK_BYTES - 1)) >> 4);
                    idx_d       = '0;
                    err_d       = bad_req;
                    state_d     = (bad_req || vl_i == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: state_d = ST_EXE;
            ST_EXE: begin
                wb_data_d = lane_res;
                wb_idx_d  = idx_q;
                for (int b = 0; b < CHUNK_BYTES; b++) begin
                    wb_be_d[b] = TB_W'(b) < rem;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                if (wb_ready_i) begin
                    if (last_chunk) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            vsew_q      <= '0;
            scalar_en_q <= 1'b0;
            scalar_q    <= '0;
            total_q     <= '0;
            nchunks_q   <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            wb_data_q   <= '0;
            wb_idx_q    <= '0;
            wb_be_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            vsew_q      <= vsew_d;
            scalar_en_q <= scalar_en_d;
            scalar_q    <= scalar_d;
            total_q     <= total_d;
            nchunks_q   <= nchunks_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            wb_data_q   <= wb_data_d;
            wb_idx_q    <= wb_idx_d;
            wb_be_q     <= wb_be_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rd_req_o    = (state_q == ST_RD);
    assign rd_idx_o    = (state_q == ST_RD) ? idx_q : '0;
    assign wb_valid_o  = (state_q == ST_WB);
    assign wb_idx_o    = wb_idx_q;
    assign wb_data_o   = wb_data_q;
    assign wb_be_o     = wb_be_q;
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_vshift_sequencer.sv
// tb/tb_vshift_sequencer.sv - randomized self-checking bench for vshift_sequencer
module tb_vshift_sequencer;

    localparam int MAXC  = 8;
    localparam int VL_W  = 8;
    localparam int IDX_W = 3;

    logic               clk = 1'b0;
    logic               rstn_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [1:0]         op_i;
    logic [2:0]         vsew_i;
    logic [VL_W-1:0]    vl_i;
    logic               scalar_en_i;
    logic [63:0]        scalar_i;
    logic               rd_req_o;
    logic [IDX_W-1:0]   rd_idx_o;
    logic [127:0]       rd_a_i;
    logic [127:0]       rd_b_i;
    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [IDX_W-1:0]   wb_idx_o;
    logic [127:0]       wb_data_o;
    logic [15:0]        wb_be_o;
    logic               done_o;
    logic               err_o;

    int checks = 0;
    int errors = 0;

    logic [127:0] vs2_m [MAXC];
    logic [127:0] vs1_m [MAXC];
    logic [127:0] cap_data [MAXC];
    logic [15:0]  cap_be [MAXC];
    int           cap_n;

    always #5 clk = ~clk;

    vshift_sequencer #(.MAX_CHUNKS(MAXC)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_i        (op_i),
        .vsew_i      (vsew_i),
        .vl_i        (vl_i),
        .scalar_en_i (scalar_en_i),
        .scalar_i    (scalar_i),
        .rd_req_o    (rd_req_o),
        .rd_idx_o    (rd_idx_o),
        .rd_a_i      (rd_a_i),
        .rd_b_i      (rd_b_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_idx_o    (wb_idx_o),
        .wb_data_o   (wb_data_o),
        .wb_be_o     (wb_be_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: per element, amount = value mod SEW; arithmetic right fills vacated bits with the sign.
    function automatic logic [127:0] exp_chunk(input logic [1:0] op, input int eb, input bit sen,
                                               input logic [63:0] scal, input logic [127:0] a_c,
                                               input logic [127:0] b_c);
        logic [127:0] r;
        logic [63:0]  a, b, mask, res, src;
        int           ew, sh;
        r  = '0;
        ew = 8 * eb;
        mask = (ew == 64) ? {64{1'b1}} : ((64'd1 << ew) - 64'd1);
        for (int e = 0; e < 16 / eb; e++) begin
            a = '0;
            b = '0;
            for (int j = 0; j < eb; j++) begin
                a[j*8 +: 8] = a_c[(e*eb + j)*8 +: 8];
                b[j*8 +: 8] = b_c[(e*eb + j)*8 +: 8];
            end
            src = sen ? scal : b;
            sh  = int'(src % 64'(ew));
            if (op == 2'b00)      res = (a << sh) & mask;
            else if (op == 2'b01) res = a >> sh;
            else                  res = (a >> sh) | (a[ew-1] ? (mask & ~(mask >> sh)) : 64'd0);
            for (int j = 0; j < eb; j++) r[(e*eb + j)*8 +: 8] = res[j*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_be(input int total, input int c);
        int rem;
        rem = total - 16 * c;
        if (rem >= 16) return 16'hFFFF;
        return 16'((32'd1 << rem) - 32'd1);
    endfunction

    task automatic fill_mem();
        for (int c = 0; c < MAXC; c++) begin
            vs2_m[c] = rnd128();
            vs1_m[c] = rnd128();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (req_ready_o !== 1'b1 || rd_req_o !== 1'b0 || rd_idx_o !== '0 || wb_valid_o !== 1'b0 ||
            wb_idx_o !== '0 || wb_data_o !== '0 || wb_be_o !== '0 || done_o !== 1'b0 || err_o !== 1'b0)
            begin
            errors++;
            $display("FAIL %s: rdy=%b rd=%b rdidx=%0d wbv=%b wbidx=%0d data=%h be=%h done=%b err=%b required rdy=1 and all else 0",
                     tag, req_ready_o, rd_req_o, rd_idx_o, wb_valid_o, wb_idx_o, wb_data_o, wb_be_o, done_o, err_o);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [2:0] vsew, input int vl, input bit sen,
                          input logic [63:0] scal, input int stall0, input bit rand_ready, input int abort_chunk);
        int  eb, vle, total, nch, k, next_rd, wb_cnt, stalls;
        bit  bad, prev_rd, done_seen;
        logic [127:0] exp_d;
        logic [15:0]  exp_b;
        bad = (op == 2'b11) || (vsew > 3'd3);
        eb = 1; total = 0; nch = 0;
        if (!bad) begin
            eb    = 1 << vsew;
            vle   = (vl > 128 / eb) ? 128 / eb : vl;
            total = vle * eb;
            nch   = (total + 15) / 16;
        end
        @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_before_accept: got %b required 1", req_ready_o);
        end
        req_valid_i = 1'b1; op_i = op; vsew_i = vsew; vl_i = VL_W'(vl);
        scalar_en_i = sen; scalar_i = scal;
        @(negedge clk);
        next_rd = 0; wb_cnt = 0; stalls = 0; prev_rd = 1'b0; done_seen = 1'b0; k = 1;
        while (!done_seen && k <= 300) begin
            req_valid_i = 1'(($urandom));
            op_i = 2'($urandom); vsew_i = 3'($urandom); vl_i = VL_W'($urandom);
            scalar_en_i = 1'($urandom); scalar_i = {$urandom, $urandom};
            if (rd_req_o) begin
                checks++;
                if (rd_idx_o !== IDX_W'(next_rd) || next_rd >= nch || wb_cnt != next_rd) begin
                    errors++;
                    $display("FAIL rd_req: idx=%0d required idx=%0d (chunks=%0d written=%0d)",
                             rd_idx_o, next_rd, nch, wb_cnt);
                end
                rd_a_i = vs2_m[rd_idx_o];
                rd_b_i = vs1_m[rd_idx_o];
                next_rd++;
            end else if (!prev_rd) begin
                rd_a_i = rnd128();
                rd_b_i = rnd128();
            end
            prev_rd = rd_req_o;
            if (wb_valid_o) begin
                checks++;
                if (wb_cnt >= nch) begin
                    errors++;
                    $display("FAIL wb_unexpected: wb_valid=1 after %0d of %0d chunks", wb_cnt, nch);
                end else begin
                    exp_d = exp_chunk(op, eb, sen, scal, vs2_m[wb_cnt], vs1_m[wb_cnt]);
                    exp_b = exp_be(total, wb_cnt);
                    if (wb_idx_o !== IDX_W'(wb_cnt) || wb_data_o !== exp_d || wb_be_o !== exp_b) begin
                        errors++;
                        $display("FAIL wb_chunk%0d: idx=%0d data=%h be=%h required idx=%0d data=%h be=%h",
                                 wb_cnt, wb_idx_o, wb_data_o, wb_be_o, wb_cnt, exp_d, exp_b);
                    end
                end
                if (abort_chunk == wb_cnt) begin
                    req_valid_i = 1'b0;
                    rstn_i = 1'b0;
                    #1;
                    check_idle_outputs("reset_mid_op");
                    cap_n = wb_cnt;
                    return;
                end
                if (wb_cnt == 0 && stalls < stall0) wb_ready_i = 1'b0;
                else if (rand_ready)                wb_ready_i = ($urandom_range(0, 3) != 0);
                else                                wb_ready_i = 1'b1;
                if (!wb_ready_i) stalls++;
                else if (wb_cnt < MAXC) begin
                    cap_data[wb_cnt] = wb_data_o;
                    cap_be[wb_cnt]   = wb_be_o;
                    wb_cnt++;
                end
            end else begin
                wb_ready_i = 1'($urandom);
            end
            if (done_o) begin
                done_seen   = 1'b1;
                req_valid_i = 1'b0;
                checks++;
                if (k != 3 * nch + 1 + stalls || err_o !== bad || wb_cnt != nch) begin
                    errors++;
                    $display("FAIL done: cycle=%0d err=%b chunks=%0d required cycle=%0d err=%b chunks=%0d",
                             k, err_o, wb_cnt, 3 * nch + 1 + stalls, bad, nch);
                end
            end else if (err_o) begin
                checks++;
                errors++;
                $display("FAIL err_without_done: err=1 required 0 at cycle %0d", k);
            end
            if (!done_seen) begin
                @(negedge clk);
                k++;
            end
        end
        req_valid_i = 1'b0;
        cap_n = wb_cnt;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done_o within 300 cycles (op=%0d vsew=%0d vl=%0d)", op, vsew, vl);
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        rstn_i = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_release");
    endtask

    task automatic test_sra_byte();
        fill_mem();
        vs2_m[0][7:0] = 8'h80; vs1_m[0][7:0]  = 8'd3;
        vs2_m[0][15:8] = 8'h7F; vs1_m[0][15:8] = 8'd7;
        run_op(2'b10, 3'd0, 16, 1'b0, 64'd0, 0, 1'b0, -1);
        checks++;
        if (cap_data[0][15:0] !== 16'h00F0 || cap_be[0] !== 16'hFFFF || cap_n != 1) begin
            errors++;
            $display("FAIL sra_byte: bytes=%h be=%h n=%0d required bytes=00f0 be=ffff n=1",
                     cap_data[0][15:0], cap_be[0], cap_n);
        end
    endtask

    task automatic test_srl_scalar();
        fill_mem();
        vs2_m[0][31:0] = 32'h8000_0010;
        run_op(2'b01, 3'd2, 10, 1'b1, 64'h24, 0, 1'b0, -1);
        checks++;
        if (cap_data[0][31:0] !== 32'h0800_0001 || cap_n != 3 || cap_be[2] !== 16'h00FF) begin
            errors++;
            $display("FAIL srl_scalar: elem=%h n=%0d last_be=%h required elem=08000001 n=3 last_be=00ff",
                     cap_data[0][31:0], cap_n, cap_be[2]);
        end
    endtask

    task automatic test_sll_64();
        logic [63:0] upper;
        fill_mem();
        vs2_m[0][63:0] = 64'h8000_0000_0000_0001; vs1_m[0][63:0] = 64'h41;
        upper = 64'h0123_4567_89AB_CDEF;
        vs2_m[0][127:64] = upper; vs1_m[0][127:64] = 64'd0;
        run_op(2'b00, 3'd3, 2, 1'b0, 64'd0, 0, 1'b0, -1);
        checks++;
        if (cap_data[0] !== {upper, 64'h2}) begin
            errors++;
            $display("FAIL sll_64: got %h required %h", cap_data[0], {upper, 64'h2});
        end
    endtask

    task automatic test_backpressure();
        fill_mem();
        run_op(2'b10, 3'd1, 24, 1'b0, 64'd0, 5, 1'b0, -1);
    endtask

    task automatic test_degenerate();
        run_op(2'b00, 3'd0, 0, 1'b0, 64'd0, 0, 1'b0, -1);
        run_op(2'b11, 3'd0, 16, 1'b0, 64'd0, 0, 1'b0, -1);
        run_op(2'b01, 3'd5, 16, 1'b0, 64'd0, 0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            fill_mem();
            run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), int'($urandom_range(0, 255)),
                   1'($urandom), {$urandom, $urandom}, 0, 1'b1, -1);
        end
    endtask

    task automatic test_reset_mid_op();
        fill_mem();
        run_op(2'b00, 3'd2, 16, 1'b0, 64'd0, 0, 1'b0, 1);
        repeat (2) begin
            @(negedge clk);
            check_idle_outputs("held_in_reset");
        end
        rstn_i = 1'b1;
        fill_mem();
        run_op(2'b10, 3'd0, 64, 1'b1, {$urandom, $urandom}, 0, 1'b0, -1);
    endtask

    initial begin
        rstn_i = 1'b0; req_valid_i = 1'b0; op_i = '0; vsew_i = '0; vl_i = '0;
        scalar_en_i = 1'b0; scalar_i = '0; rd_a_i = '0; rd_b_i = '0; wb_ready_i = 1'b1;
        cap_n = 0;
        test_reset();
        test_sra_byte();
        test_srl_scalar();
        test_sll_64();
        test_backpressure();
        test_degenerate();
        test_random();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
